// File: rtl/c_xbar_conn_ctrl.sv
// Crossbar connection holder between the VC stage and the wavefront allocator:
// masks requests for busy ports, latches grants until tail/timeout, drives selects.
module c_xbar_conn_ctrl #(
  parameter int num_ports    = 8,
  parameter int idle_timeout = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic [num_ports*num_ports-1:0] req_in,
  output logic [num_ports*num_ports-1:0] req_out,
  input  logic [num_ports*num_ports-1:0] gnt,
  output logic                           update,
  input  logic [num_ports-1:0]           flit_valid_ip,
  input  logic [num_ports-1:0]           flit_tail_ip,
  output logic [num_ports*num_ports-1:0] conn,
  output logic [num_ports*num_ports-1:0] xbar_sel_op,
  output logic [num_ports-1:0]           busy_ip,
  output logic [num_ports-1:0]           busy_op,
  output logic                           err
);

  localparam int P  = num_ports;
  localparam int CW = (idle_timeout > 0) ? $clog2(idle_timeout + 1) : 1;
  localparam logic [CW-1:0] L_TC  = CW'((idle_timeout > 0) ? idle_timeout - 1 : 0);
  localparam logic [CW-1:0] L_SAT = '1;
  localparam logic [P-1:0]  L_ONE = P'(1);

  logic [P*P-1:0] r_conn;
  logic [CW-1:0]  r_cnt [P];
  logic           r_err;

  logic [P-1:0]   w_row_any;
  logic [P-1:0]   w_timeout;
  logic [P-1:0]   w_release;
  logic [P-1:0]   w_busy_eff_ip;
  logic [P-1:0]   w_busy_eff_op;
  logic [P-1:0]   w_busy_op;
  logic [P*P-1:0] w_req_out;
  logic [P*P-1:0] w_gnt_t;
  logic [P*P-1:0] w_conn_t;
  logic [P-1:0]   w_row_multi;
  logic [P-1:0]   w_col_multi;
  logic [P*P-1:0] w_acc;
  logic           w_gnt_err;
  logic           w_flit_err;

  always_comb begin
    w_row_any     = '0;
    w_timeout     = '0;
    w_release     = '0;
    w_busy_op     = '0;
    w_busy_eff_op = '0;
    w_gnt_t       = '0;
    w_conn_t      = '0;
    for (int i = 0; i < P; i++) begin
      w_row_any[i] = |r_conn[i*P +: P];
      w_timeout[i] = (idle_timeout != 0) && w_row_any[i] && (r_cnt[i] == L_TC);
      w_release[i] = w_row_any[i] &
                     ((flit_valid_ip[i] & flit_tail_ip[i]) | w_timeout[i]);
    end
    for (int i = 0; i < P; i++) begin
      for (int o = 0; o < P; o++) begin
        w_gnt_t[o*P+i]  = gnt[i*P+o];
        w_conn_t[o*P+i] = r_conn[i*P+o];
        w_busy_op[o]     = w_busy_op[o] | r_conn[i*P+o];
        // a connection being released this cycle no longer blocks its column
        w_busy_eff_op[o] = w_busy_eff_op[o] | (r_conn[i*P+o] & ~w_release[i]);
      end
    end
    w_busy_eff_ip = w_row_any & ~w_release;
  end

  always_comb begin
    w_req_out   = '0;
    w_row_multi = '0;
    w_col_multi = '0;
    w_acc       = '0;
    for (int i = 0; i < P; i++) begin
      w_row_multi[i] = |(gnt[i*P +: P] & (gnt[i*P +: P] - L_ONE));
      w_col_multi[i] = |(w_gnt_t[i*P +: P] & (w_gnt_t[i*P +: P] - L_ONE));
    end
    for (int i = 0; i < P; i++) begin
      for (int o = 0; o < P; o++) begin
        w_req_out[i*P+o] = req_in[i*P+o] & ~w_busy_eff_ip[i] & ~w_busy_eff_op[o];
        w_acc[i*P+o]     = gnt[i*P+o] & w_req_out[i*P+o] &
                           ~w_row_multi[i] & ~w_col_multi[o];
      end
    end
    w_gnt_err  = (|(gnt & ~w_req_out)) | (|w_row_multi) | (|w_col_multi);
    w_flit_err = |(flit_valid_ip & ~w_row_any);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conn <= '0;
      r_err  <= 1'b0;
      for (int i = 0; i < P; i++) r_cnt[i] <= '0;
    end else if (active) begin
      r_err <= r_err | w_gnt_err | w_flit_err;
      for (int i = 0; i < P; i++) begin
        if (|w_acc[i*P +: P]) begin
          r_conn[i*P +: P] <= w_acc[i*P +: P];
          r_cnt[i]         <= '0;
        end else if (w_release[i]) begin
          r_conn[i*P +: P] <= '0;
          r_cnt[i]         <= '0;
        end else if (w_row_any[i]) begin
          if (flit_valid_ip[i])       r_cnt[i] <= '0;
          else if (r_cnt[i] != L_SAT) r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign req_out     = w_req_out;
  assign update      = |w_acc;
  assign conn        = r_conn;
  assign xbar_sel_op = w_conn_t;
  assign busy_ip     = w_row_any;
  assign busy_op     = w_busy_op;
  assign err         = r_err;

endmodule

// File: tb/tb_c_xbar_conn_ctrl.sv
// Directed bench for c_xbar_conn_ctrl, P=4 with a 3-cycle idle timeout.
module tb_c_xbar_conn_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        active;
  logic [15:0] req_in;
  logic [15:0] req_out;
  logic [15:0] gnt;
  logic        update;
  logic [3:0]  flit_valid_ip;
  logic [3:0]  flit_tail_ip;
  logic [15:0] conn;
  logic [15:0] xbar_sel_op;
  logic [3:0]  busy_ip;
  logic [3:0]  busy_op;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  c_xbar_conn_ctrl #(.num_ports(4), .idle_timeout(3)) dut (
    .clk(clk), .reset(reset), .active(active),
    .req_in(req_in), .req_out(req_out), .gnt(gnt), .update(update),
    .flit_valid_ip(flit_valid_ip), .flit_tail_ip(flit_tail_ip),
    .conn(conn), .xbar_sel_op(xbar_sel_op),
    .busy_ip(busy_ip), .busy_op(busy_op), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b0; active = 1'b1;
    req_in = 16'hA5A5; gnt = '0; flit_valid_ip = '0; flit_tail_ip = '0;
    #3;
    chk("rst_conn", conn, 16'h0000);
    chk("rst_busy_ip", {12'h0, busy_ip}, 16'h0000);
    chk("rst_busy_op", {12'h0, busy_op}, 16'h0000);
    chk("rst_xbar", xbar_sel_op, 16'h0000);
    chk("rst_err", {15'h0, err}, 16'h0000);
    chk("rst_update", {15'h0, update}, 16'h0000);
    chk("rst_req_out", req_out, 16'hA5A5);
    tick();
    reset = 1'b1; req_in = '0;
    tick();

    // T1/T2: grant 1->2, three-flit packet, back-to-back grant 3->2 in tail cycle
    req_in = 16'h10C4; gnt = 16'h0040;
    settle();
    chk("t1_update", {15'h0, update}, 16'h0001);
    chk("t1_req_out_free", req_out, 16'h10C4);
    tick();
    gnt = '0; flit_valid_ip = 4'b0010;
    chk("t1_conn", conn, 16'h0040);
    chk("t1_xbar", xbar_sel_op, 16'h0200);
    chk("t1_busy_ip", {12'h0, busy_ip}, 16'h0002);
    chk("t1_busy_op", {12'h0, busy_op}, 16'h0004);
    settle();
    chk("t1_req_out_mask", req_out, 16'h1000);
    chk("t1_update_idle", {15'h0, update}, 16'h0000);
    tick();
    tick();
    flit_tail_ip = 4'b0010; req_in = 16'h4000; gnt = 16'h4000;
    settle();
    chk("t2_req_out_release", req_out, 16'h4000);
    chk("t2_update", {15'h0, update}, 16'h0001);
    tick();
    req_in = '0; gnt = '0; flit_valid_ip = 4'b1000; flit_tail_ip = 4'b1000;
    chk("t2_conn", conn, 16'h4000);
    chk("t2_xbar", xbar_sel_op, 16'h0800);
    chk("t2_busy_op", {12'h0, busy_op}, 16'h0004);
    tick();
    flit_valid_ip = '0; flit_tail_ip = '0;
    chk("t2_conn_done", conn, 16'h0000);
    chk("t2_err", {15'h0, err}, 16'h0000);

    // T3: single-flit packet on 0->0
    req_in = 16'h0001; gnt = 16'h0001;
    tick();
    req_in = '0; gnt = '0; flit_valid_ip = 4'b0001; flit_tail_ip = 4'b0001;
    chk("t3_conn", conn, 16'h0001);
    tick();
    flit_valid_ip = '0; flit_tail_ip = '0;
    chk("t3_conn_done", conn, 16'h0000);
    chk("t3_err", {15'h0, err}, 16'h0000);

    // T4: idle timeout on 2->1, then the same connection kept alive by flits
    req_in = 16'h0200; gnt = 16'h0200;
    tick();
    req_in = '0; gnt = '0;
    chk("t4_conn", conn, 16'h0200);
    tick();
    req_in = 16'h0002;
    settle();
    chk("t4_req_out_held", req_out, 16'h0000);
    tick();
    settle();
    chk("t4_req_out_timeout", req_out, 16'h0002);
    tick();
    req_in = '0;
    chk("t4_conn_timeout", conn, 16'h0000);
    req_in = 16'h0200; gnt = 16'h0200;
    tick();
    req_in = '0; gnt = '0; flit_valid_ip = 4'b0100;
    repeat (6) tick();
    chk("t4_conn_alive", conn, 16'h0200);
    flit_tail_ip = 4'b0100;
    tick();
    flit_valid_ip = '0; flit_tail_ip = '0;
    chk("t4_conn_tail", conn, 16'h0000);

    // T5: grant to a busy output, then a double grant in one row next to a legal one
    req_in = 16'h1000; gnt = 16'h1000;
    tick();
    flit_valid_ip = 4'b1000; req_in = 16'h0010; gnt = 16'h0010;
    settle();
    chk("t5_req_out_busy", req_out, 16'h0000);
    chk("t5_update_drop", {15'h0, update}, 16'h0000);
    tick();
    req_in = '0; gnt = '0;
    chk("t5_conn_kept", conn, 16'h1000);
    chk("t5_err_set", {15'h0, err}, 16'h0001);
    flit_tail_ip = 4'b1000;
    tick();
    flit_valid_ip = '0; flit_tail_ip = '0;
    chk("t5_conn_done", conn, 16'h0000);
    req_in = 16'h0806; gnt = 16'h0806;
    settle();
    chk("t5_req_out_multi", req_out, 16'h0806);
    chk("t5_update_legal", {15'h0, update}, 16'h0001);
    tick();
    req_in = '0; gnt = '0; flit_valid_ip = 4'b0100; flit_tail_ip = 4'b0100;
    chk("t5_conn_legal_only", conn, 16'h0800);
    tick();
    flit_valid_ip = '0; flit_tail_ip = '0;
    chk("t5_conn_clear", conn, 16'h0000);
    chk("t5_err_sticky", {15'h0, err}, 16'h0001);

    // T6: async reset mid-packet, then freeze with active=0
    req_in = 16'h0020; gnt = 16'h0020;
    tick();
    req_in = '0; gnt = '0; flit_valid_ip = 4'b0010;
    chk("t6_conn", conn, 16'h0020);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_conn", conn, 16'h0000);
    chk("t6_rst_busy_ip", {12'h0, busy_ip}, 16'h0000);
    chk("t6_rst_busy_op", {12'h0, busy_op}, 16'h0000);
    chk("t6_rst_xbar", xbar_sel_op, 16'h0000);
    chk("t6_rst_err", {15'h0, err}, 16'h0000);
    tick();
    reset = 1'b1; flit_valid_ip = '0;
    tick();
    req_in = 16'h0400; gnt = 16'h0400;
    tick();
    active = 1'b0;
    req_in = 16'h0001; gnt = 16'h0001;
    flit_valid_ip = 4'b1100; flit_tail_ip = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t6_frozen_conn", conn, 16'h0400);
      chk("t6_frozen_err", {15'h0, err}, 16'h0000);
    end
    active = 1'b1; req_in = '0; gnt = '0;
    flit_valid_ip = 4'b0100; flit_tail_ip = 4'b0100;
    tick();
    flit_valid_ip = '0; flit_tail_ip = '0;
    chk("t6_resume_conn", conn, 16'h0000);
    chk("t6_resume_err", {15'h0, err}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
